// File: rtl/data_bus_pkg.sv
// Shared types for the two-master data BRAM arbiter.
// Master identifiers, the per-master request bundle and the default word-address width.
package data_bus_pkg;

    localparam int DATA_BUS_ADDR_W = 30;

    typedef enum logic [1:0] {
        M0   = 2'd0,
        M1   = 2'd1,
        NONE = 2'd2
    } bus_master_e;

    typedef struct packed {
        logic                       req;
        logic                       we;
        logic                       lock;
        logic [DATA_BUS_ADDR_W-1:0] addr;
        logic [3:0]                 mask;
        logic [31:0]                wdata;
    } bus_req_t;

endpackage

// File: rtl/data_bus_arbiter.sv
// Shares the single-ported data BRAM between the core (m0, priority) and a loader/DMA (m1).
// Grant is combinational (0 cycles), read data returns 1 enabled cycle later; m1 is starvation-protected.
module data_bus_arbiter
    import data_bus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = DATA_BUS_ADDR_W
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic              clk_en,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m0_mask,
    input  logic [3:0]        m1_mask,
    input  logic [31:0]       m0_wdata,
    input  logic [31:0]       m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [31:0]       m0_rdata,
    output logic [31:0]       m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_mask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    bus_master_e owner_q;
    logic        lock_q;
    logic [7:0]  starve_cnt;
    logic        tag_vld;
    logic        tag_id;

    bus_req_t    m0_r;
    bus_req_t    m1_r;
    bus_req_t    sel_r;
    logic        owner_req;
    logic        owner_lock;
    logic        any_gnt;

    // Addresses are carried in the package-width field; ADDR_W must not exceed it.
    assign m0_r = '{req: m0_req, we: m0_we, lock: m0_lock,
                    addr: DATA_BUS_ADDR_W'(m0_addr), mask: m0_mask, wdata: m0_wdata};
    assign m1_r = '{req: m1_req, we: m1_we, lock: m1_lock,
                    addr: DATA_BUS_ADDR_W'(m1_addr), mask: m1_mask, wdata: m1_wdata};

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (clk_en && !sync_rst) begin
            if (lock_q) begin
                if (owner_q == M0) begin
                    m0_gnt = m0_req;
                end else if (owner_q == M1) begin
                    m1_gnt = m1_req;
                end
            end else if (starve_cnt == LIMIT && m1_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_lock = 1'b0;
        case (owner_q)
            M0:      begin owner_req = m0_req; owner_lock = m0_lock; end
            M1:      begin owner_req = m1_req; owner_lock = m1_lock; end
            default: begin owner_req = 1'b0;   owner_lock = 1'b0;    end
        endcase
    end

    assign sel_r     = m1_gnt ? m1_r : m0_r;
    assign any_gnt   = (m0_gnt | m1_gnt) & sel_r.req;
    assign mem_en    = any_gnt;
    assign mem_we    = any_gnt & sel_r.we;
    assign mem_addr  = ADDR_W'(sel_r.addr);
    assign mem_mask  = sel_r.mask;
    assign mem_wdata = sel_r.wdata;

    // The tag is only consumed on an enabled edge, so rvalid stays visible while clk_en is low.
    assign m0_rvalid = tag_vld & ~tag_id & ~sync_rst;
    assign m1_rvalid = tag_vld &  tag_id & ~sync_rst;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            owner_q    <= NONE;
            lock_q     <= 1'b0;
            starve_cnt <= 8'd0;
            tag_vld    <= 1'b0;
            tag_id     <= 1'b0;
        end else if (clk_en) begin
            if (any_gnt) begin
                owner_q <= m1_gnt ? M1 : M0;
                lock_q  <= sel_r.lock;
            end else if (!owner_req || !owner_lock) begin
                lock_q  <= 1'b0;
            end

            // Saturating at the limit lets a locked m0 hold m1 off until the lock drops.
            if (!m1_req || m1_gnt) begin
                starve_cnt <= 8'd0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 8'd1;
            end

            tag_vld <= any_gnt & ~sel_r.we;
            tag_id  <= m1_gnt;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a behavioural one-cycle-latency BRAM.
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic        clk_en;
    logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
    logic [29:0] m0_addr, m1_addr;
    logic [3:0]  m0_mask, m1_mask;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    logic [31:0] ram [0:255];
    logic        ram_load;

    int errors = 0;
    int checks = 0;

    data_bus_arbiter #(.STARVE_LIMIT(4), .ADDR_W(30)) dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_mask(m0_mask), .m1_mask(m1_mask),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_mask(mem_mask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[8'h10] <= 32'hDEADBEEF;
            ram[8'h20] <= 32'h11111111;
            ram[8'h21] <= 32'h11111111;
            ram[8'h22] <= 32'h11111111;
            ram[8'h30] <= 32'hAAAAAAAA;
            ram[8'h60] <= 32'h12345678;
            ram[8'h61] <= 32'h87654321;
        end else if (clk_en && mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_lock = 0; m1_lock = 0;
        m0_addr = '0; m1_addr = '0; m0_mask = 4'hF; m1_mask = 4'hF;
        m0_wdata = '0; m1_wdata = '0;
    endtask

    initial begin
        idle();
        ram_load = 1; sync_rst = 1; clk_en = 1;
        cyc();
        ram_load = 0;

        // reset: requests present but everything forced low
        m0_req = 1; m0_addr = 30'h10;
        #1;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        cyc();
        chk("rst_cnt", dut.starve_cnt, 0);
        chk("rst_owner", dut.owner_q, 2);
        m0_req = 0; sync_rst = 0;
        cyc();

        // single m0 read of 0x10
        m0_req = 1; m0_addr = 30'h10;
        #1;
        chk("rd_m0_gnt", m0_gnt, 1);
        chk("rd_m1_gnt", m1_gnt, 0);
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 32'h10);
        cyc();
        m0_req = 0;
        #1;
        chk("rd_m0_rvalid", m0_rvalid, 1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rvalid", m1_rvalid, 0);
        cyc();
        chk("rd_rvalid_one", m0_rvalid, 0);

        // continuous contention: M0 x4, M1, M0 x4, M1
        m0_req = 1; m0_addr = 30'h40; m1_req = 1; m1_addr = 30'h41;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("starve_m1_gnt_%0d", i), m1_gnt, (i == 4 || i == 9));
            chk($sformatf("starve_m0_gnt_%0d", i), m0_gnt, !(i == 4 || i == 9));
            chk($sformatf("starve_cnt_%0d", i), dut.starve_cnt, i % 5);
            cyc();
        end
        m0_req = 0; m1_req = 0;
        #1;
        chk("starve_cnt_after", dut.starve_cnt, 0);
        cyc();

        // m1 locked burst of three masked writes while m0 waits
        m1_req = 1; m1_we = 1; m1_lock = 1; m1_mask = 4'h3;
        m1_addr = 30'h20; m1_wdata = 32'hA5A50020;
        #1;
        chk("lk_m1_gnt0", m1_gnt, 1);
        chk("lk_mem_we", mem_we, 1);
        chk("lk_mem_mask", mem_mask, 4'h3);
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = 30'h30;
        m1_addr = 30'h21; m1_wdata = 32'hA5A50021;
        #1;
        chk("lk_m1_gnt1", m1_gnt, 1);
        chk("lk_m0_held1", m0_gnt, 0);
        cyc();
        m1_addr = 30'h22; m1_wdata = 32'hA5A50022; m1_lock = 0;
        #1;
        chk("lk_m1_gnt2", m1_gnt, 1);
        chk("lk_m0_held2", m0_gnt, 0);
        cyc();
        m1_req = 0; m1_we = 0; m1_mask = 4'hF;
        #1;
        chk("lk_m0_gnt", m0_gnt, 1);
        chk("lk_mem_addr", mem_addr, 32'h30);
        cyc();
        m0_req = 0;
        #1;
        chk("lk_m0_rvalid", m0_rvalid, 1);
        chk("lk_m0_rdata", m0_rdata, 32'hAAAAAAAA);
        chk("lk_ram20", ram[8'h20], 32'h11110020);
        chk("lk_ram21", ram[8'h21], 32'h11110021);
        chk("lk_ram22", ram[8'h22], 32'h11110022);
        cyc();

        // clk_en 1,0,0,1 around a granted read
        m0_req = 1; m0_addr = 30'h10;
        #1;
        chk("en_gnt", m0_gnt, 1);
        cyc();
        clk_en = 0;
        #1;
        chk("en_off_gnt0", m0_gnt, 0);
        chk("en_off_mem_en0", mem_en, 0);
        chk("en_off_rvalid0", m0_rvalid, 1);
        chk("en_off_rdata0", m0_rdata, 32'hDEADBEEF);
        cyc();
        chk("en_off_gnt1", m0_gnt, 0);
        chk("en_off_rvalid1", m0_rvalid, 1);
        chk("en_off_rdata1", m0_rdata, 32'hDEADBEEF);
        cyc();
        clk_en = 1; m0_req = 0;
        #1;
        chk("en_on_rvalid", m0_rvalid, 1);
        chk("en_on_mem_en", mem_en, 0);
        cyc();
        chk("en_rvalid_done", m0_rvalid, 0);

        // sync_rst the cycle after an m1 read grant
        m1_req = 1; m1_addr = 30'h10;
        #1;
        chk("sr_m1_gnt", m1_gnt, 1);
        cyc();
        sync_rst = 1; m0_req = 1; m0_addr = 30'h30;
        #1;
        chk("sr_m1_rvalid", m1_rvalid, 0);
        chk("sr_m0_gnt", m0_gnt, 0);
        chk("sr_m1_gnt_rst", m1_gnt, 0);
        chk("sr_mem_en", mem_en, 0);
        cyc();
        sync_rst = 0;
        #1;
        chk("sr_cnt", dut.starve_cnt, 0);
        chk("sr_post_m1_rvalid", m1_rvalid, 0);
        chk("sr_post_m0_gnt", m0_gnt, 1);
        cyc();
        m0_req = 0; m1_req = 0;
        #1;
        chk("sr_post_m0_rvalid", m0_rvalid, 1);
        chk("sr_post_rdata", m0_rdata, 32'hAAAAAAAA);
        chk("sr_post_m1_rv", m1_rvalid, 0);
        cyc();

        // write then read of 0x60: read sees new data
        m0_req = 1; m0_we = 1; m0_addr = 30'h60; m0_wdata = 32'h0BADF00D;
        m1_req = 1; m1_addr = 30'h60;
        #1;
        chk("wr_first_m0", m0_gnt, 1);
        cyc();
        m0_req = 0; m0_we = 0;
        #1;
        chk("wr_first_m1", m1_gnt, 1);
        chk("wr_no_rvalid", m0_rvalid, 0);
        cyc();
        m1_req = 0;
        #1;
        chk("wr_first_rvalid", m1_rvalid, 1);
        chk("wr_first_rdata", m1_rdata, 32'h0BADF00D);
        cyc();

        // read then write of 0x61: read sees old data
        m1_req = 1; m1_addr = 30'h61;
        #1;
        chk("rd_first_m1", m1_gnt, 1);
        cyc();
        m1_req = 0;
        m0_req = 1; m0_we = 1; m0_addr = 30'h61; m0_wdata = 32'hFFFF0000;
        #1;
        chk("rd_first_m0", m0_gnt, 1);
        chk("rd_first_rvalid", m1_rvalid, 1);
        chk("rd_first_rdata", m1_rdata, 32'h87654321);
        cyc();
        m0_req = 0; m0_we = 0;
        #1;
        chk("rd_first_wr_norv", m0_rvalid, 0);
        chk("rd_first_ram61", ram[8'h61], 32'hFFFF0000);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter that shares the single-ported data BRAM between the core data port (master 0) and a secondary bus master such as a program loader or DMA engine (master 1). It sits between the masters and the data RAM, issuing one access per enabled cycle and routing the one-cycle-latency read data back to the master that issued the read. Master 0 has priority, with a starvation counter and a lock input so master 1 is guaranteed forward progress and atomic sequences stay intact.

## Interface
- STARVE_LIMIT, 4: consecutive denied cycles of master 1 before it is forced a grant; legal range 1..255.
- ADDR_W, 30: word address width.
- clk  in  1  system clock.
- sync_rst  in  1  synchronous active-high reset.
- clk_en  in  1  global clock enable; state advances only when high.
- m0_req, m1_req  in  1 each  access request.
- m0_we, m1_we  in  1 each  1 = write, 0 = read.
- m0_lock, m1_lock  in  1 each  holds ownership after the current grant.
- m0_addr, m1_addr  in  ADDR_W each  word address.
- m0_mask, m1_mask  in  4 each  byte-lane write mask.
- m0_wdata, m1_wdata  in  32 each  write data.
- m0_gnt, m1_gnt  out  1 each  request accepted this cycle.
- m0_rvalid, m1_rvalid  out  1 each  read data valid for that master.
- m0_rdata, m1_rdata  out  32 each  read data, which is mem_rdata fanned out.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_mask  out  4  RAM byte mask.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid one enabled cycle after mem_en.

## Operation
- Grant is combinational from the requests and the registered state. At most one gnt is high per cycle. All gnt and mem_en outputs are forced to 0 while clk_en = 0.
- Owner register (M0/M1/NONE) plus lock flag:
  - If the lock flag is set, only the owner can be granted.
  - Otherwise, if the starvation counter equals STARVE_LIMIT and m1_req is high, grant m1.
  - Otherwise, m0 wins when it requests, and m1 wins when m0 is idle.
- Lock flag: on an enabled granted cycle, it is set to the granted master's lock input. It is cleared on any enabled cycle where the owner is not requesting or its lock input is low.
- Starvation counter, 8 bits:
  - Increments on an enabled cycle with m1_req = 1 and m1_gnt = 0.
  - Clears when m1 is granted or when m1_req = 0.
  - Saturates at STARVE_LIMIT.
  - A locked m0 may hold the counter at the limit; m1 is granted on the first unlocked cycle.
- The mem_* outputs mux the granted master's addr, we, mask and wdata. mem_en = a gnt is high.
- Read return: a registered tag (valid, id) captures a granted read. On the next enabled cycle, the matching mx_rvalid = 1.
- Writes produce no rvalid.
- Simultaneous events:
  - A grant in the same cycle as an outstanding rvalid is legal; back-to-back reads from either master are pipelined at one per cycle.
  - Request inputs must stay stable until gnt. The arbiter may change the winner only between enabled cycles.

## Timing
- Reset values: owner NONE, lock flag 0, counter 0, tag invalid.
- Output values in reset: every gnt/rvalid/mem_en = 0.
- Grant latency: 0 cycles, so a request is granted in the same cycle when it wins.
- Read latency: rvalid is asserted exactly 1 enabled cycle after the grant and lasts one enabled cycle.
- clk_en low: all registers hold, including a pending rvalid, which stays visible until the next enabled cycle consumes it.
- sync_rst mid-read: the tag is dropped; no rvalid is issued after reset.
- Worst-case m1 wait without lock: STARVE_LIMIT + 1 enabled cycles.

## Structure
- Shared package data_bus_pkg:
  - bus_master_e (M0, M1, NONE).
  - bus_req_t struct (req, we, lock, addr, mask, wdata).
  - The default address width constant.
- Flat module, with no sub-module needed. The starvation logic and read-tag pipeline are small enough to stay inline.

## Test plan
- Only m0 reads addr 0x10 with RAM word 0xDEADBEEF: m0_gnt in the same cycle, m0_rvalid with 0xDEADBEEF 1 cycle later, m1_rvalid stays 0.
- m0 and m1 request continuously, STARVE_LIMIT = 4: grant pattern M0×4, M1, M0×4, M1; counter returns to 0 after each m1 grant.
- m1 holds lock for 3 writes to 0x20..0x22 while m0 requests: m1 granted 3 consecutive cycles, then m0; RAM holds the m1 data with the mask applied (mask 0x3 writes the low 2 bytes only).
- clk_en toggled 1,0,0,1 during a granted read: gnt/mem_en low while disabled, rvalid held, then returns exactly one enabled cycle after the grant.
- sync_rst asserted the cycle after an m1 read grant: no m1_rvalid, all outputs 0, counter 0, first post-reset request granted normally.
- Interleaved m0 write and m1 read to the same address: the read returns the data written if the write was granted earlier, otherwise the old data.
